layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
Parametrised, pipelined successor to the game's per-pixel colour selection. Composites N sprite/projectile/HUD layers, a text overlay and a background source into VGA RGB with fixed priority. Adds per-layer hit-flash and a frame-synchronous fade-to/from-black engine for stage transitions (start/battle/win/lose). Sits between the sprite/word/background generators and the VGA output pins.

Parameters:
N_LAYERS, 4, number of priority layers; layer 0 has the highest priority.
COLOR_W, 8, bits per colour channel.
FADE_SHIFT, 4, fade resolution; level runs 0..2^FADE_SHIFT, one step per frame.
FLASH_FRAMES, 8, length of a hit-flash in frames.

Ports:
Clk  in  1  system clock (pixel clock domain)
Reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse per frame, at vblank start
pix_valid  in  1  current DrawX/DrawY is in the visible area
layer_on  in  N_LAYERS  per-layer pixel-opaque flags
layer_rgb  in  N_LAYERS*3*COLOR_W  packed {R,G,B} per layer; layer i at slice i
bg_rgb  in  3*COLOR_W  background colour
text_on  in  1  text overlay pixel active
text_rgb  in  3*COLOR_W  text colour
flash_req  in  N_LAYERS  one-cycle request to start or retrigger a flash on a layer
fade_start  in  1  one-cycle fade launch
fade_dir  in  1  0 = fade in from black, 1 = fade out to black; sampled with fade_start
VGA_R, VGA_G, VGA_B  out  COLOR_W each  composited colour
out_valid  out  1  pix_valid delayed by 2 cycles
fade_busy  out  1  fade FSM is in FADING
fade_done  out  1  one-cycle pulse when a fade completes

Behaviour:
- Reset (asynchronous, Reset_n=0): VGA_R/G/B=0, out_valid=0, fade_busy=0, fade_done=0, level=2^FADE_SHIFT (full brightness), FSM=IDLE, all flash counters=0. A reset during a fade aborts it and restores full brightness.
- Latency is 2 cycles, fixed, from layer_*/bg/text/pix_valid to VGA_*/out_valid. No stalls.
- Stage 1 (registered) does the selection, with priority text_on > layer 0 > ... > layer N-1 > bg_rgb.
  - If the winning layer i has flash_cnt[i] odd, the stage-1 colour is all-ones (white).
  - A stage-1 is_text flag is registered alongside the colour.
- Stage 2 (registered) scales each channel: out = (c * level) >> FADE_SHIFT.
  - Product width is COLOR_W+FADE_SHIFT+1. No rounding (truncate).
  - level=2^FADE_SHIFT returns c exactly; level=0 returns 0.
  - Text pixels bypass scaling, so text stays legible during a fade.
  - If the stage-1 valid bit is 0, the outputs are forced to 0 (blanking).
- Fade FSM, states IDLE and FADING:
  - IDLE with fade_start=1: latch dir. Set level=0 for dir=0 or level=2^FADE_SHIFT for dir=1. Go to FADING and set fade_busy=1.
  - FADING: on each frame_start, level +1 (dir 0) or -1 (dir 1).
  - When level reaches its target (2^FADE_SHIFT or 0) the FSM goes to IDLE on that same edge and pulses fade_done for 1 cycle.
  - fade_start during FADING is ignored.
  - If fade_start and frame_start arrive in the same cycle, the level is initialised only; there is no step that cycle.
  - level changes only on frame_start (or a launch), so it is constant across the visible frame.
  - After a fade out, level stays 0 (screen black) until the next fade in or reset.
- Flash counters, one per layer, width $clog2(FLASH_FRAMES+1):
  - flash_req[i] loads FLASH_FRAMES. A request during an active flash retriggers it.
  - On frame_start the counter decrements if nonzero.
  - If req and frame_start coincide, req wins (counter loads FLASH_FRAMES).
  - The resulting flash pattern alternates white/normal per frame, FLASH_FRAMES/2 white frames, and the counter saturates at 0.

Decomposition:
- Package gfx_pkg holds:
  - typedef rgb_t, a packed struct {r,g,b} of COLOR_W each;
  - typedef fade_state_e {IDLE, FADING};
  - constants COLOR_WHITE and COLOR_BLACK.
- One sub-module, fade_scaler: a purely combinational per-channel multiply-shift with the text bypass, instantiated 3 times in stage 2.
- Priority select and flash counters live in the top.

Test Plan:
- Reset and latency: layer_on=0001, layer0=FF8000, pix_valid=1, level full -> VGA = FF/80/00 exactly 2 cycles later, out_valid aligned; Reset_n low mid-stream -> outputs 0 immediately.
- Priority: text_on=1 with layer_on=1111 -> text_rgb; text_on=0, layer_on=1010, layer1=00FF00, layer3=0000FF -> 00FF00; layer_on=0 -> bg_rgb; pix_valid=0 -> 000000.
- Fade out, FADE_SHIFT=4: fade_start, dir=1, bg=C8C8C8 -> fade_busy=1. After 8 frame_starts, level=8 -> 64/64/64. After 16, fade_done pulses once, output 0, text still full colour.
- Fade in with a collision: fade_start and frame_start in the same cycle, dir=0 -> level=0 that frame. Exactly 16 further frame_starts reach 2^4 and fade_done. A second fade_start mid-fade is ignored (fade_done count = 1).
- Flash: flash_req[2] with layer2 winning and FLASH_FRAMES=8 -> output alternates FFFFFF/normal over 8 frames, then stays normal. A retrigger at frame 5 restarts 8 frames. req coinciding with frame_start loads 8.
- Non-winning flash: flash_req[3] while layer 0 covers the pixel -> no white at that pixel, but layer 3's counter still decrements.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared colour and fade types for the layer compositor.
// Imported by the compositor top and by the testbench.
package gfx_pkg;

   localparam int PKG_COLOR_W = 8;

   typedef struct packed {
      logic [PKG_COLOR_W-1:0] r;
      logic [PKG_COLOR_W-1:0] g;
      logic [PKG_COLOR_W-1:0] b;
   } rgb_t;

   typedef enum logic {
      IDLE,
      FADING
   } fade_state_e;

   localparam rgb_t COLOR_WHITE = '{r: '1, g: '1, b: '1};
   localparam rgb_t COLOR_BLACK = '{r: '0, g: '0, b: '0};

endpackage

// File: rtl/fade_scaler.sv
// Per-channel brightness scaler: (c * level) >> FADE_SHIFT.
// Text pixels pass through untouched so they stay legible.
module fade_scaler #(
   parameter int COLOR_W    = 8,
   parameter int FADE_SHIFT = 4
) (
   input  logic [COLOR_W-1:0]  c_in,
   input  logic [FADE_SHIFT:0] level,
   input  logic                bypass,
   output logic [COLOR_W-1:0]  c_out
);

   localparam int PROD_W = COLOR_W + FADE_SHIFT + 1;

   logic [PROD_W-1:0] prod;

   // multiply, truncate the fraction, or bypass for text
   always_comb begin
      prod  = PROD_W'(c_in) * PROD_W'(level);
      c_out = bypass ? c_in : COLOR_W'(prod >> FADE_SHIFT);
   end

endmodule

// File: rtl/layer_compositor.sv
// Fixed-priority layer compositor with hit-flash and fade engine.
// Two-stage pipeline: select/flash, then fade scaling and blanking.
module layer_compositor
   import gfx_pkg::*;
#(
   parameter int N_LAYERS     = 4,
   parameter int COLOR_W      = 8,
   parameter int FADE_SHIFT   = 4,
   parameter int FLASH_FRAMES = 8
) (
   input  logic                            Clk,
   input  logic                            Reset_n,
   input  logic                            frame_start,
   input  logic                            pix_valid,
   input  logic [N_LAYERS-1:0]             layer_on,
   input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
   input  logic [3*COLOR_W-1:0]            bg_rgb,
   input  logic                            text_on,
   input  logic [3*COLOR_W-1:0]            text_rgb,
   input  logic [N_LAYERS-1:0]             flash_req,
   input  logic                            fade_start,
   input  logic                            fade_dir,
   output logic [COLOR_W-1:0]              VGA_R,
   output logic [COLOR_W-1:0]              VGA_G,
   output logic [COLOR_W-1:0]              VGA_B,
   output logic                            out_valid,
   output logic                            fade_busy,
   output logic                            fade_done
);

   localparam int PIX_W = 3 * COLOR_W;
   localparam int LVL_W = FADE_SHIFT + 1;
   localparam int FL_W  = $clog2(FLASH_FRAMES + 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(1 << FADE_SHIFT);
   localparam logic [PIX_W-1:0] WHITE = {PIX_W{1'b1}};

   fade_state_e state_q, state_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic dir_q, dir_d;
   logic done_q, done_d;

   logic [N_LAYERS-1:0][FL_W-1:0] flash_q, flash_d;

   logic [PIX_W-1:0] col1_q, col1_d;
   logic txt1_q, txt1_d;
   logic vld1_q, vld1_d;

   logic [PIX_W-1:0] scaled;
   logic [PIX_W-1:0] pix2_q, pix2_d;
   logic vld2_q, vld2_d;

   // stage 1: text > layer 0 > ... > layer N-1 > background
   always_comb begin
      col1_d = bg_rgb;
      txt1_d = 1'b0;
      vld1_d = pix_valid;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (layer_on[i]) begin
            col1_d = flash_q[i][0] ? WHITE : layer_rgb[i*PIX_W +: PIX_W];
         end
      end
      if (text_on) begin
         col1_d = text_rgb;
         txt1_d = 1'b1;
      end
   end

   // flash counters: request (re)loads, frame start counts down to 0
   always_comb begin
      flash_d = flash_q;
      for (int i = 0; i < N_LAYERS; i++) begin
         if (flash_req[i]) begin
            flash_d[i] = FL_W'(FLASH_FRAMES);
         end else if (frame_start && flash_q[i] != '0) begin
            flash_d[i] = flash_q[i] - 1'b1;
         end
      end
   end

   // fade FSM: launch sets the start level, each frame steps once
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fade_start) begin
               dir_d   = fade_dir;
               level_d = fade_dir ? LVL_FULL : '0;
               state_d = FADING;
            end
         end
         FADING: begin
            if (frame_start) begin
               level_d = dir_q ? level_q - 1'b1 : level_q + 1'b1;
               if (level_d == (dir_q ? '0 : LVL_FULL)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   fade_scaler #(.COLOR_W(COLOR_W), .FADE_SHIFT(FADE_SHIFT)) u_scale_r (
      .c_in   (col1_q[2*COLOR_W +: COLOR_W]),
      .level  (level_q),
      .bypass (txt1_q),
      .c_out  (scaled[2*COLOR_W +: COLOR_W])
   );

   fade_scaler #(.COLOR_W(COLOR_W), .FADE_SHIFT(FADE_SHIFT)) u_scale_g (
      .c_in   (col1_q[COLOR_W +: COLOR_W]),
      .level  (level_q),
      .bypass (txt1_q),
      .c_out  (scaled[COLOR_W +: COLOR_W])
   );

   fade_scaler #(.COLOR_W(COLOR_W), .FADE_SHIFT(FADE_SHIFT)) u_scale_b (
      .c_in   (col1_q[0 +: COLOR_W]),
      .level  (level_q),
      .bypass (txt1_q),
      .c_out  (scaled[0 +: COLOR_W])
   );

   // stage 2: blank outside the visible area
   always_comb begin
      pix2_d = vld1_q ? scaled : '0;
      vld2_d = vld1_q;
   end

   // pipeline registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         col1_q <= '0;
         txt1_q <= 1'b0;
         vld1_q <= 1'b0;
         pix2_q <= '0;
         vld2_q <= 1'b0;
      end else begin
         col1_q <= col1_d;
         txt1_q <= txt1_d;
         vld1_q <= vld1_d;
         pix2_q <= pix2_d;
         vld2_q <= vld2_d;
      end
   end

   // fade and flash state; reset returns to full brightness
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         level_q <= LVL_FULL;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
         flash_q <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         flash_q <= flash_d;
      end
   end

   assign VGA_R     = pix2_q[2*COLOR_W +: COLOR_W];
   assign VGA_G     = pix2_q[COLOR_W +: COLOR_W];
   assign VGA_B     = pix2_q[0 +: COLOR_W];
   assign out_valid = vld2_q;
   assign fade_busy = (state_q == FADING);
   assign fade_done = done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor with a frame-level model.
// Directed priority/fade/flash scenarios followed by random traffic.
module tb_layer_compositor;
   import gfx_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [3:0]  layer_on = '0;
   logic [95:0] layer_rgb = '0;
   logic [23:0] bg_rgb = '0;
   logic        text_on = 1'b0;
   logic [23:0] text_rgb = '0;
   logic [3:0]  flash_req = '0;
   logic        fade_start = 1'b0;
   logic        fade_dir = 1'b0;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        out_valid, fade_busy, fade_done;

   layer_compositor #(
      .N_LAYERS(4), .COLOR_W(8), .FADE_SHIFT(4), .FLASH_FRAMES(8)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
      .pix_valid(pix_valid), .layer_on(layer_on), .layer_rgb(layer_rgb),
      .bg_rgb(bg_rgb), .text_on(text_on), .text_rgb(text_rgb),
      .flash_req(flash_req), .fade_start(fade_start), .fade_dir(fade_dir),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .out_valid(out_valid), .fade_busy(fade_busy), .fade_done(fade_done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [23:0] pix;
      logic        vld;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   bit   run = 1'b0;
   int   done_cnt = 0;

   // reference model state
   int          lvl = 16;
   bit          fading = 1'b0;
   bit          mdir = 1'b0;
   int          fc[4] = '{0, 0, 0, 0};
   bit          s1_vld = 1'b0;
   bit          s1_txt = 1'b0;
   logic [23:0] s1_col = '0;
   exp_t        me;
   exp_t        mon;
   bit          m_dn;
   bit          hit;

   task automatic check(input string name, input logic [23:0] act,
                        input logic [23:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
      end
   endtask

   function automatic logic [23:0] scale(input logic [23:0] c, input int l);
      int r, g, b;
      r = int'(c[23:16]) * l / 16;
      g = int'(c[15:8]) * l / 16;
      b = int'(c[7:0]) * l / 16;
      return {8'(r), 8'(g), 8'(b)};
   endfunction

   task automatic model_reset();
      lvl = 16;
      fading = 1'b0;
      mdir = 1'b0;
      for (int i = 0; i < 4; i++) fc[i] = 0;
      s1_vld = 1'b0;
      s1_txt = 1'b0;
      s1_col = '0;
   endtask

   // model: each clock edge produces the expected output of that edge
   initial forever begin
      @(posedge Clk);
      if (run) begin
         me.vld = s1_vld;
         if (!s1_vld) me.pix = '0;
         else if (s1_txt) me.pix = s1_col;
         else me.pix = scale(s1_col, lvl);
         s1_vld = pix_valid;
         s1_txt = text_on;
         if (text_on) begin
            s1_col = text_rgb;
         end else begin
            s1_col = bg_rgb;
            hit = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (!hit && layer_on[i]) begin
                  hit = 1'b1;
                  s1_col = (fc[i] % 2 == 1) ? 24'hFFFFFF : layer_rgb[i*24 +: 24];
               end
            end
         end
         m_dn = 1'b0;
         if (!fading) begin
            if (fade_start) begin
               mdir = fade_dir;
               lvl = fade_dir ? 16 : 0;
               fading = 1'b1;
            end
         end else if (frame_start) begin
            lvl = mdir ? lvl - 1 : lvl + 1;
            if (lvl == (mdir ? 0 : 16)) begin
               fading = 1'b0;
               m_dn = 1'b1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (flash_req[i]) fc[i] = 8;
            else if (frame_start && fc[i] > 0) fc[i] = fc[i] - 1;
         end
         me.busy = fading;
         me.done = m_dn;
         exp_q.push_back(me);
      end
   end

   // monitor: pop and compare every presented output
   initial forever begin
      @(posedge Clk);
      #1;
      if (Reset_n && fade_done) done_cnt++;
      if (run) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty got=none want=entry t=%0t", $time);
         end else begin
            mon = exp_q.pop_front();
            check("pix", {VGA_R, VGA_G, VGA_B}, mon.pix);
            check("out_valid", 24'(out_valid), 24'(mon.vld));
            check("fade_busy", 24'(fade_busy), 24'(mon.busy));
            check("fade_done", 24'(fade_done), 24'(mon.done));
         end
      end
   end

   task automatic tick();
      @(negedge Clk);
      frame_start = 1'b0;
      fade_start = 1'b0;
      flash_req = '0;
   endtask

   task automatic frame(input int gap);
      repeat (gap) tick();
      frame_start = 1'b1;
      tick();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 24'h0);
      check({tag, "_valid"}, 24'(out_valid), 24'h0);
      check({tag, "_busy"}, 24'(fade_busy), 24'h0);
      check({tag, "_done"}, 24'(fade_done), 24'h0);
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      check_reset("por");
      Reset_n = 1'b1;
      run = 1'b1;

      // latency with a single opaque layer
      pix_valid = 1'b1;
      layer_on = 4'b0001;
      layer_rgb[23:0] = 24'hFF8000;
      repeat (4) tick();

      // priority cases
      layer_rgb = {24'h0000FF, 24'h123456, 24'h00FF00, 24'hFF8000};
      text_rgb = 24'hABCDEF;
      text_on = 1'b1;
      layer_on = 4'b1111;
      repeat (2) tick();
      text_on = 1'b0;
      layer_on = 4'b1010;
      repeat (2) tick();
      layer_on = 4'b0000;
      bg_rgb = 24'h102030;
      repeat (2) tick();
      pix_valid = 1'b0;
      repeat (2) tick();
      pix_valid = 1'b1;

      // fade out over 16 frames
      bg_rgb = 24'hC8C8C8;
      fade_dir = 1'b1;
      fade_start = 1'b1;
      tick();
      for (int f = 1; f <= 16; f++) frame(3);
      repeat (3) tick();
      check("fade_out_done_cnt", 24'(done_cnt), 24'd1);
      text_on = 1'b1;
      repeat (3) tick();
      text_on = 1'b0;
      repeat (2) tick();

      // fade in launched on a frame edge, with an ignored relaunch
      fade_dir = 1'b0;
      fade_start = 1'b1;
      frame_start = 1'b1;
      tick();
      for (int f = 1; f <= 16; f++) begin
         repeat (3) tick();
         if (f == 5) begin
            fade_start = 1'b1;
            fade_dir = 1'b1;
         end
         frame_start = 1'b1;
         tick();
         if (f == 15) begin
            repeat (2) tick();
            check("fade_in_early_cnt", 24'(done_cnt), 24'd1);
         end
      end
      fade_dir = 1'b0;
      repeat (3) tick();
      check("fade_in_done_cnt", 24'(done_cnt), 24'd2);

      // flash on the winning layer, with retriggers
      layer_on = 4'b0100;
      layer_rgb[71:48] = 24'h336699;
      flash_req = 4'b0100;
      tick();
      for (int f = 1; f <= 20; f++) begin
         if (f == 9) begin
            flash_req = 4'b0100;
            tick();
         end
         repeat (3) tick();
         if (f == 5) flash_req = 4'b0100;
         frame_start = 1'b1;
         tick();
      end

      // flash on a covered layer still counts down
      layer_on = 4'b1001;
      flash_req = 4'b1000;
      tick();
      for (int f = 1; f <= 3; f++) frame(3);
      layer_on = 4'b1000;
      repeat (4) tick();
      for (int f = 1; f <= 6; f++) frame(3);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         pix_valid = ($urandom_range(0, 7) != 0);
         layer_on = 4'($urandom);
         layer_rgb = {$urandom, $urandom, $urandom};
         bg_rgb = 24'($urandom);
         text_on = ($urandom_range(0, 7) == 0);
         text_rgb = 24'($urandom);
         frame_start = (c % 16 == 0);
         fade_start = ($urandom_range(0, 49) == 0);
         fade_dir = 1'($urandom);
         flash_req = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
         tick();
      end

      // reset in the middle of a fade
      pix_valid = 1'b1;
      text_on = 1'b0;
      layer_on = 4'b0001;
      layer_rgb[23:0] = 24'hFF8000;
      fade_dir = 1'b1;
      repeat (3) tick();
      fade_start = 1'b1;
      tick();
      for (int f = 1; f <= 3; f++) frame(3);
      Reset_n = 1'b0;
      run = 1'b0;
      #1;
      check_reset("mid");
      exp_q.delete();
      model_reset();
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      run = 1'b1;
      repeat (10) tick();
      run = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
